// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with same-cycle
// write bypass, one synchronous write port, a raw debug read port and a
// counter of committed writes. Register 0 is hardwired to zero.
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              re1,
  input  logic [ADDR_W-1:0] r_addr1,
  output logic [DATA_W-1:0] r_data1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic [DATA_W-1:0] r_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              wr_commit;

  // A write commits only for a non-zero destination; r0 writes are dropped.
  always_comb begin
    wr_commit  = we && (w_addr != '0);
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // Array and counter state; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      if (wr_commit) begin
        mem_q[w_addr] <= w_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Read port 1: reset, enable and r0 force zero; otherwise bypass wins over the array.
  always_comb begin
    r_data1 = '0;
    if (rst && re1 && (r_addr1 != '0)) begin
      if (we && (w_addr == r_addr1)) begin
        r_data1 = w_data;
      end else begin
        r_data1 = mem_q[r_addr1];
      end
    end
  end

  // Read port 2: identical priority to port 1, fully independent.
  always_comb begin
    r_data2 = '0;
    if (rst && re2 && (r_addr2 != '0)) begin
      if (we && (w_addr == r_addr2)) begin
        r_data2 = w_data;
      end else begin
        r_data2 = mem_q[r_addr2];
      end
    end
  end

  // Debug port shows raw array contents only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (rst) begin
      dbg_data = mem_q[dbg_addr];
    end
  end

  assign wr_count = rst ? wr_count_q : 32'd0;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        re1;
  logic [4:0]  r_addr1;
  logic [31:0] r_data1;
  logic        re2;
  logic [4:0]  r_addr2;
  logic [31:0] r_data2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;

  int vectors;
  int miscompares;

  regfile #(
    .DATA_W(32),
    .ADDR_W(5),
    .NREG  (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .re1     (re1),
    .r_addr1 (r_addr1),
    .r_data1 (r_data1),
    .re2     (re2),
    .r_addr2 (r_addr2),
    .r_data2 (r_data2),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one write at the negedge, commit it on the posedge, then drop we.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we     = 1'b1;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    we = 1'b0; w_addr = '0; w_data = '0;
    re1 = 1'b1; re2 = 1'b1; r_addr1 = '0; r_addr2 = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r_addr1 = 5'(i); r_addr2 = 5'(i); dbg_addr = 5'(i);
      #1;
      vectors++;
      if (r_data1 !== 32'd0 || r_data2 !== 32'd0 || dbg_data !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_read addr=%0d r1=%h r2=%h dbg=%h required 0", i, r_data1,
                 r_data2, dbg_data);
      end
    end
    vectors++;
    if (wr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_count got=%h required=0", wr_count);
    end
  endtask

  task automatic test_write_readback;
    do_write(5'd5, 32'hDEAD_BEEF);
    r_addr1 = 5'd5; r_addr2 = 5'd5; dbg_addr = 5'd5;
    #1;
    vectors++;
    if (r_data1 !== 32'hDEAD_BEEF || r_data2 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL readback r1=%h r2=%h required=deadbeef", r_data1, r_data2);
    end
    vectors++;
    if (dbg_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL readback_dbg got=%h required=deadbeef", dbg_data);
    end
    vectors++;
    if (wr_count !== 32'd1) begin
      miscompares++;
      $display("FAIL readback_count got=%0d required=1", wr_count);
    end
  endtask

  task automatic test_bypass;
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    we = 1'b1; w_addr = 5'd7; w_data = 32'h2222_2222;
    r_addr1 = 5'd7; r_addr2 = 5'd7; dbg_addr = 5'd7;
    #1;
    vectors++;
    if (r_data1 !== 32'h2222_2222 || r_data2 !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_pre r1=%h r2=%h required=22222222", r_data1, r_data2);
    end
    vectors++;
    if (dbg_data !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL bypass_dbg_pre got=%h required=11111111", dbg_data);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    vectors++;
    if (r_data1 !== 32'h2222_2222 || dbg_data !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL bypass_post r1=%h dbg=%h required=22222222", r_data1, dbg_data);
    end
    vectors++;
    if (wr_count !== 32'd3) begin
      miscompares++;
      $display("FAIL bypass_count got=%0d required=3", wr_count);
    end
  endtask

  task automatic test_r0_enables;
    @(negedge clk);
    we = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF; r_addr1 = 5'd0;
    #1;
    vectors++;
    if (r_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL r0_bypass got=%h required=0", r_data1);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    vectors++;
    if (r_data1 !== 32'd0 || wr_count !== 32'd3) begin
      miscompares++;
      $display("FAIL r0_write r1=%h count=%0d required r1=0 count=3", r_data1, wr_count);
    end
    do_write(5'd3, 32'h1234_5678);
    re2 = 1'b0; r_addr2 = 5'd3;
    #1;
    vectors++;
    if (r_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL re2_off got=%h required=0", r_data2);
    end
    re2 = 1'b1;
    #1;
    vectors++;
    if (r_data2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL re2_on got=%h required=12345678", r_data2);
    end
    re1 = 1'b0; r_addr1 = 5'd3;
    #1;
    vectors++;
    if (r_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL re1_off got=%h required=0", r_data1);
    end
    re1 = 1'b1;
  endtask

  task automatic test_async_reset;
    do_write(5'd1, 32'hA000_0001);
    do_write(5'd2, 32'hA000_0002);
    do_write(5'd3, 32'hA000_0003);
    do_write(5'd4, 32'hA000_0004);
    r_addr1 = 5'd2; r_addr2 = 5'd9; dbg_addr = 5'd4;
    #1;
    vectors++;
    if (r_data1 !== 32'hA000_0002 || dbg_data !== 32'hA000_0004 || wr_count !== 32'd8) begin
      miscompares++;
      $display("FAIL pre_reset r1=%h dbg=%h count=%0d required a0000002 a0000004 8",
               r_data1, dbg_data, wr_count);
    end
    @(negedge clk);
    we = 1'b1; w_addr = 5'd9; w_data = 32'hBAD0_BAD0;
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (r_data1 !== 32'd0 || r_data2 !== 32'd0 || dbg_data !== 32'd0 || wr_count !== 32'd0)
    begin
      miscompares++;
      $display("FAIL async_reset r1=%h r2=%h dbg=%h count=%0d required all 0", r_data1,
               r_data2, dbg_data, wr_count);
    end
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      r_addr1 = 5'(i); dbg_addr = 5'(i);
      #1;
      vectors++;
      if (r_data1 !== 32'd0 || dbg_data !== 32'd0) begin
        miscompares++;
        $display("FAIL post_reset addr=%0d r1=%h dbg=%h required 0", i, r_data1, dbg_data);
      end
    end
    r_addr2 = 5'd9; dbg_addr = 5'd9;
    #1;
    vectors++;
    if (r_data2 !== 32'd0 || dbg_data !== 32'd0 || wr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL lost_write r2=%h dbg=%h count=%0d required 0", r_data2, dbg_data,
               wr_count);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    vectors++;
    if (wr_count !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_preset got=%h required=ffffffff", wr_count);
    end
    do_write(5'd2, 32'h0000_0042);
    vectors++;
    if (wr_count !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap got=%h required=0", wr_count);
    end
    r_addr1 = 5'd2;
    #1;
    vectors++;
    if (r_data1 !== 32'h0000_0042) begin
      miscompares++;
      $display("FAIL wrap_data got=%h required=42", r_data1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_readback();
    test_bypass();
    test_r0_enables();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
